// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the RAM port arbiter.
package ram_arb_pkg;

  localparam int unsigned DefaultAw = 25;

  typedef enum logic [1:0] {
    StIdle,
    StDlAcc,
    StCpuAcc,
    StCpuRec
  } arb_state_e;

endpackage

// File: rtl/dl_fifo.sv
// Synchronous FIFO buffering download writes; pointers carry an extra wrap bit.
module dl_fifo #(
  parameter int unsigned Width = 33,
  parameter int unsigned Depth = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic             overflow_pulse
);

  localparam int unsigned IdxW = $clog2(Depth);
  localparam logic [IdxW:0] PtrOne = {{IdxW{1'b0}}, 1'b1};

  logic [Width-1:0] mem_q [Depth];
  logic [IdxW:0]    wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[IdxW] != rd_ptr_q[IdxW]) &&
                 (wr_ptr_q[IdxW-1:0] == rd_ptr_q[IdxW-1:0]);

  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign do_pop         = pop && !empty;
  assign do_push        = push && (!full || do_pop);
  assign overflow_pulse = push && !do_push;
  assign rdata          = mem_q[rd_ptr_q[IdxW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[IdxW-1:0]] <= wdata;
  end

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates the external RAM port between buffered download writes (absolute
// priority) and CPU request/acknowledge accesses.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned AW         = DefaultAw,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          dl_active,
  input  logic          dl_wr,
  input  logic [AW-1:0] dl_addr,
  input  logic [7:0]    dl_data,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_wdata,
  output logic [7:0]    cpu_rdata,
  output logic          cpu_ack,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata,
  input  logic          mem_ack,
  output logic          dl_overflow
);

  localparam int unsigned EntryW = AW + 8;

  arb_state_e        state_q, state_d;
  logic              fifo_pop, fifo_full, fifo_empty, overflow_pulse;
  logic [EntryW-1:0] fifo_rdata;
  logic              dl_active_q;
  logic              mem_req_d, mem_we_d, cpu_ack_d, dl_overflow_d;
  logic [AW-1:0]     mem_addr_d;
  logic [7:0]        mem_wdata_d, cpu_rdata_d;
  logic              unused_fifo_full;

  dl_fifo #(
    .Width (EntryW),
    .Depth (FIFO_DEPTH)
  ) u_dl_fifo (
    .clk            (clk),
    .reset          (reset),
    .push           (dl_wr),
    .wdata          ({dl_addr, dl_data}),
    .pop            (fifo_pop),
    .rdata          (fifo_rdata),
    .full           (fifo_full),
    .empty          (fifo_empty),
    .overflow_pulse (overflow_pulse)
  );

  // Drop handling lives in the FIFO; the full flag is not needed here.
  assign unused_fifo_full = fifo_full;

  always_comb begin
    state_d     = state_q;
    fifo_pop    = 1'b0;
    mem_req_d   = mem_req;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    cpu_ack_d   = 1'b0;
    cpu_rdata_d = cpu_rdata;

    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop    = 1'b1;
          mem_addr_d  = fifo_rdata[EntryW-1:8];
          mem_wdata_d = fifo_rdata[7:0];
          mem_we_d    = 1'b1;
          mem_req_d   = 1'b1;
          state_d     = StDlAcc;
        end else if (cpu_req && !dl_active && !dl_wr) begin
          // A strobe landing in the FIFO this cycle still outranks the CPU.
          mem_addr_d  = cpu_addr;
          mem_wdata_d = cpu_wdata;
          mem_we_d    = cpu_we;
          mem_req_d   = 1'b1;
          state_d     = StCpuAcc;
        end
      end
      StDlAcc: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = StIdle;
        end
      end
      StCpuAcc: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          cpu_ack_d = 1'b1;
          if (!mem_we) cpu_rdata_d = mem_rdata;
          state_d   = StCpuRec;
        end
      end
      StCpuRec: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    dl_overflow_d = dl_overflow;
    if (overflow_pulse)               dl_overflow_d = 1'b1;
    else if (dl_active && !dl_active_q) dl_overflow_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      cpu_ack     <= 1'b0;
      cpu_rdata   <= '0;
      dl_overflow <= 1'b0;
      dl_active_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req     <= mem_req_d;
      mem_we      <= mem_we_d;
      mem_addr    <= mem_addr_d;
      mem_wdata   <= mem_wdata_d;
      cpu_ack     <= cpu_ack_d;
      cpu_rdata   <= cpu_rdata_d;
      dl_overflow <= dl_overflow_d;
      dl_active_q <= dl_active;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: memory responder, access log and reference memory model.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        dl_active, dl_wr, cpu_req, cpu_we, mem_ack;
  logic [24:0] dl_addr, cpu_addr, mem_addr;
  logic [7:0]  dl_data, cpu_wdata, cpu_rdata, mem_wdata, mem_rdata;
  logic        cpu_ack, mem_req, mem_we, dl_overflow;

  int total = 0;
  int bad   = 0;
  int ack_cnt = 0;
  int ack_delay = 0;
  logic ack_hold = 1'b0;
  logic [7:0] last_rd = 8'h00;

  // Entry: {we, addr, data}; reads carry data 0.
  logic [33:0] acc_log[$];
  logic [33:0] exp_q[$];
  logic [7:0]  ram     [logic [24:0]];
  logic [7:0]  ref_mem [logic [24:0]];

  ram_arbiter #(
    .AW         (25),
    .FIFO_DEPTH (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .dl_active   (dl_active),
    .dl_wr       (dl_wr),
    .dl_addr     (dl_addr),
    .dl_data     (dl_data),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .cpu_ack     (cpu_ack),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack),
    .dl_overflow (dl_overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (cpu_ack) ack_cnt <= ack_cnt + 1;

  function automatic logic [7:0] dflt(input logic [24:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Memory: acks ack_delay+1 cycles after mem_req rises unless ack_hold is set.
  initial begin : responder
    int cnt;
    logic busy;
    logic [33:0] snap;
    mem_ack = 1'b0; mem_rdata = 8'h00; cnt = 0; busy = 1'b0; snap = '0;
    forever begin
      @(negedge clk);
      if (mem_ack) begin
        mem_ack = 1'b0;
        chk("mem_req_drop", mem_req, 1'b0);
        busy = 1'b0; cnt = 0;
      end else if (reset || !mem_req) begin
        busy = 1'b0; cnt = 0;
      end else begin
        if (!busy) begin
          busy = 1'b1; cnt = 0;
          snap = {mem_we, mem_addr, mem_wdata};
        end
        if (!ack_hold) begin
          if (cnt >= ack_delay) begin
            chk("mem_stable", {mem_we, mem_addr, mem_wdata}, snap);
            if (mem_we) begin
              ram[mem_addr] = mem_wdata;
              acc_log.push_back({1'b1, mem_addr, mem_wdata});
            end else begin
              mem_rdata = ram.exists(mem_addr) ? ram[mem_addr] : dflt(mem_addr);
              acc_log.push_back({1'b0, mem_addr, 8'h00});
            end
            mem_ack = 1'b1;
          end else begin
            cnt++;
          end
        end
      end
    end
  end

  task automatic dl_write(input logic [24:0] a, input logic [7:0] d, input logic accept);
    dl_wr = 1'b1; dl_addr = a; dl_data = d;
    if (accept) begin
      exp_q.push_back({1'b1, a, d});
      ref_mem[a] = d;
    end
    @(negedge clk);
    dl_wr = 1'b0;
  endtask

  task automatic cpu_access(input logic we, input logic [24:0] a, input logic [7:0] d);
    int acks0;
    logic ok;
    logic [7:0] exp_rd;
    acks0 = ack_cnt;
    ok = 1'b0;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (cpu_ack) ok = 1'b1;
    end
    chk("cpu_ack_seen", ok, 1'b1);
    if (we) begin
      ref_mem[a] = d;
      exp_q.push_back({1'b1, a, d});
      chk("rdata_hold", cpu_rdata, last_rd);
    end else begin
      exp_rd = ref_mem.exists(a) ? ref_mem[a] : dflt(a);
      exp_q.push_back({1'b0, a, 8'h00});
      chk("cpu_rdata", cpu_rdata, exp_rd);
      last_rd = exp_rd;
    end
    @(negedge clk);
    chk("cpu_ack_pulse", cpu_ack, 1'b0);
    cpu_req = 1'b0;
    tick(3);
    chk("cpu_ack_count", 64'(ack_cnt - acks0), 64'd1);
  endtask

  task automatic drain();
    int i;
    i = 0;
    while ((acc_log.size() != exp_q.size() || mem_req) && i < 300) begin
      @(negedge clk);
      i++;
    end
    chk("drain_timeout", i < 300, 1'b1);
  endtask

  task automatic compare_log(input string tag);
    chk({tag, "_count"}, 64'(acc_log.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < acc_log.size(); i++)
      chk(tag, acc_log[i], exp_q[i]);
    acc_log.delete();
    exp_q.delete();
  endtask

  initial begin : watchdog
    #400_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    reset = 1'b1;
    dl_active = 1'b0; dl_wr = 1'b0; dl_addr = '0; dl_data = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    tick(3);
    chk("rst_ctrl", {mem_req, mem_we, cpu_ack, dl_overflow}, 4'b0000);
    chk("rst_mem_addr", mem_addr, 25'h0);
    chk("rst_data", {mem_wdata, cpu_rdata}, 16'h0000);
    reset = 1'b0;
    tick(2);

    // Single download write: mem_req two cycles after the strobe.
    ack_delay = 0;
    dl_write(25'h200000, 8'hA5, 1'b1);
    chk("t1_not_yet", mem_req, 1'b0);
    @(negedge clk);
    chk("t1_req", {mem_req, mem_we}, 2'b11);
    chk("t1_addr", mem_addr, 25'h200000);
    chk("t1_data", mem_wdata, 8'hA5);
    drain();
    compare_log("t1_log");

    // Burst of four, slow memory.
    ack_delay = 2;
    dl_active = 1'b1;
    for (int i = 0; i < 4; i++) dl_write(25'h100000 + 25'(i), 8'(8'h10 + i), 1'b1);
    drain();
    compare_log("t2_log");
    chk("t2_ovf", dl_overflow, 1'b0);

    // Overflow: six strobes with memory stalled; the sixth is dropped.
    dl_active = 1'b0;
    tick(1);
    dl_active = 1'b1;
    tick(1);
    ack_hold = 1'b1;
    for (int i = 0; i < 6; i++) dl_write(25'h300000 + 25'(i), 8'(8'hC0 + i), i < 5);
    tick(14);
    ack_hold = 1'b0;
    drain();
    compare_log("t3_log");
    chk("t3_ovf_set", dl_overflow, 1'b1);
    dl_active = 1'b0;
    tick(2);
    chk("t3_ovf_sticky", dl_overflow, 1'b1);
    dl_active = 1'b1;
    tick(2);
    chk("t3_ovf_clear", dl_overflow, 1'b0);

    // CPU hold-off during a download.
    ack_delay = 0;
    dl_write(25'h000010, 8'h3C, 1'b1);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 25'h000010; cpu_wdata = 8'h00;
    tick(12);
    chk("t4_no_grant", mem_req, 1'b0);
    chk("t4_no_ack", 64'(ack_cnt), 64'd0);
    compare_log("t4_dl_log");
    dl_active = 1'b0;
    cpu_access(1'b0, 25'h000010, 8'h00);
    chk("t4_rdata", cpu_rdata, 8'h3C);
    compare_log("t4_log");

    // Simultaneous CPU request and download strobe.
    ack_delay = 1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 25'h000020; cpu_wdata = 8'h77;
    dl_write(25'h000030, 8'h11, 1'b1);
    cpu_access(1'b1, 25'h000020, 8'h77);
    drain();
    compare_log("t5_log");

    // Reset in the middle of a download access with two entries queued.
    ack_hold = 1'b1;
    dl_active = 1'b1;
    for (int i = 0; i < 3; i++) dl_write(25'h400000 + 25'(i), 8'(i), 1'b0);
    tick(2);
    chk("t6_busy", mem_req, 1'b1);
    reset = 1'b1;
    #1;
    chk("t6_req_drop", {mem_req, mem_we}, 2'b00);
    chk("t6_addr_clr", mem_addr, 25'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    ack_hold = 1'b0;
    tick(10);
    chk("t6_no_retry", mem_req, 1'b0);
    chk("t6_rdata_clr", cpu_rdata, 8'h00);
    last_rd = 8'h00;
    compare_log("t6_log");

    // Randomised mix of download writes and CPU accesses.
    for (int it = 0; it < 40; it++) begin
      int op;
      op = int'($urandom_range(0, 9));
      ack_delay = int'($urandom_range(0, 3));
      if (op < 5) begin
        dl_active = 1'b1;
        dl_write(25'h1000 + 25'($urandom_range(0, 15)), 8'($urandom), 1'b1);
        tick(int'($urandom_range(5, 8)));
      end else begin
        dl_active = 1'b0;
        cpu_access(1'($urandom_range(0, 1)), 25'h1000 + 25'($urandom_range(0, 15)),
                   8'($urandom));
      end
    end
    dl_active = 1'b0;
    drain();
    compare_log("rand_log");
    chk("rand_ovf", dl_overflow, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
